// File: rtl/out_port_pkg.sv
// Shared types and helpers for the OUT-port controller.
package out_port_pkg;

  typedef enum logic {StIdle, StStrobe} state_e;

  localparam int unsigned DefDataW = 8;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and a level counter for full/empty.
module sync_fifo
  import out_port_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned LvlW  = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [LvlW-1:0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q;
  logic              do_push, do_pop;

  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the level counter gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/out_port_ctrl.sv
// Queues OUT writes and presents them on O_Port with a strobe/ack handshake and ack timeout.
module out_port_ctrl
  import out_port_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  localparam int unsigned LvlW       = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              out_we,
  input  logic [DATA_W-1:0] out_data,
  output logic              stall,
  output logic [DATA_W-1:0] O_Port,
  output logic              o_stb,
  input  logic              o_ack,
  input  logic              err_clr,
  output logic              timeout_err,
  output logic [LvlW-1:0]   level
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam bit TimeoutEn = (ACK_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] port_q, port_d;
  logic              err_q, err_d;
  logic              fifo_pop, fifo_full, fifo_empty, timeout_hit;
  logic [DATA_W-1:0] fifo_head;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (out_we & ~fifo_full),
    .pop   (fifo_pop),
    .din   (out_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    port_d      = port_q;
    fifo_pop    = 1'b0;
    timeout_hit = 1'b0;
    err_d       = err_q & ~err_clr;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          port_d   = fifo_head;
          cnt_d    = '0;
          state_d  = StStrobe;
        end
      end
      StStrobe: begin
        if (!o_ack) begin
          timeout_hit = TimeoutEn && (cnt_q == CntLast);
          cnt_d       = cnt_q + 1'b1;
        end
        // A timeout retires the word exactly like an ack; O_Port keeps the dropped value.
        if (o_ack || timeout_hit) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            port_d   = fifo_head;
          end else begin
            state_d = StIdle;
          end
        end
        if (timeout_hit) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      port_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      err_q   <= err_d;
    end
  end

  assign stall       = out_we & fifo_full;
  assign O_Port      = port_q;
  assign o_stb       = (state_q == StStrobe);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Directed bench: instance a uses ACK_TIMEOUT=15, instance b disables the timeout.
module tb_out_port_ctrl;
  import out_port_pkg::*;

  localparam int unsigned DataW = 8;
  localparam int unsigned Depth = 4;
  localparam int unsigned LvlW  = level_w(Depth);

  logic             clk = 1'b0;
  logic             rstn, out_we, o_ack, err_clr;
  logic [DataW-1:0] out_data;

  logic             stall_a, stb_a, err_a, stall_b, stb_b, err_b;
  logic [DataW-1:0] port_a, port_b;
  logic [LvlW-1:0]  level_a, level_b;

  logic [DataW-1:0] got [$];
  logic [DataW-1:0] burst [3];
  logic             acc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  out_port_ctrl #(.DATA_W(DataW), .DEPTH(Depth), .ACK_TIMEOUT(15)) u_dut_a (
    .clk(clk), .rstn(rstn), .out_we(out_we), .out_data(out_data), .stall(stall_a),
    .O_Port(port_a), .o_stb(stb_a), .o_ack(o_ack), .err_clr(err_clr),
    .timeout_err(err_a), .level(level_a)
  );

  out_port_ctrl #(.DATA_W(DataW), .DEPTH(Depth), .ACK_TIMEOUT(0)) u_dut_b (
    .clk(clk), .rstn(rstn), .out_we(out_we), .out_data(out_data), .stall(stall_b),
    .O_Port(port_b), .o_stb(stb_b), .o_ack(o_ack), .err_clr(err_clr),
    .timeout_err(err_b), .level(level_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rstn = 1'b0; out_we = 1'b0; o_ack = 1'b0; err_clr = 1'b0; out_data = '0;
    tick;
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    do_reset;

    smp;
    check_eq("rst_port",  port_a,  0);
    check_eq("rst_stb",   stb_a,   0);
    check_eq("rst_err",   err_a,   0);
    check_eq("rst_level", level_a, 0);
    check_eq("rst_stall", stall_a, 0);
    tick;

    // Single write, ack tied high
    o_ack = 1'b1; out_we = 1'b1; out_data = 8'h55;
    smp; check_eq("single_stall", stall_a, 0);
    tick; out_we = 1'b0;
    smp; check_eq("single_stb_n1", stb_a, 0);
    tick;
    smp; check_eq("single_port_n2", port_a, 8'h55); check_eq("single_stb_n2", stb_a, 1);
    tick;
    smp; check_eq("single_stb_n3", stb_a, 0); check_eq("single_hold_n3", port_a, 8'h55);
    tick;

    // Burst, ack tied high
    for (int i = 0; i < 3; i++) begin
      out_we = 1'b1; out_data = burst[i];
      smp;
      check_eq("burst_stall", stall_a, 0);
      if (i == 2) begin
        check_eq("burst_port0", port_a, burst[0]);
        check_eq("burst_stb0", stb_a, 1);
      end
      tick;
    end
    out_we = 1'b0;
    smp; check_eq("burst_port1", port_a, 8'h22); check_eq("burst_stb1", stb_a, 1);
    tick;
    smp; check_eq("burst_port2", port_a, 8'h33); check_eq("burst_stb2", stb_a, 1);
    tick;
    smp; check_eq("burst_end_stb", stb_a, 0);
    tick;

    // Backpressure on the no-timeout instance
    do_reset;
    for (int i = 0; i < 5; i++) begin
      out_we = 1'b1; out_data = 8'hA0 + 8'(i);
      tick;
    end
    out_data = 8'hA5;
    smp;
    check_eq("bp_stall", stall_b, 1);
    check_eq("bp_level", level_b, 4);
    check_eq("bp_port",  port_b,  8'hA0);
    check_eq("bp_stb",   stb_b,   1);
    tick;
    repeat (20) tick;
    smp;
    check_eq("bp_held_stall", stall_b, 1);
    check_eq("bp_held_port",  port_b,  8'hA0);
    check_eq("bp_no_err",     err_b,   0);
    tick;
    o_ack = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      smp;
      if (c == 0) check_eq("bp_no_passthru", stall_b, 1);
      if (stb_b) got.push_back(port_b);
      acc = out_we && !stall_b;
      tick;
      if (acc) out_we = 1'b0;
    end
    check_eq("bp_drain_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      check_eq("bp_drain_word", got[i], 8'hA0 + 8'(i));

    // Ack timeout on instance a
    do_reset;
    out_we = 1'b1; out_data = 8'h7E;
    tick; out_data = 8'h7F;
    tick; out_we = 1'b0;
    smp; check_eq("to_first", port_a, 8'h7E); check_eq("to_first_stb", stb_a, 1);
    tick;
    repeat (13) tick;
    smp; check_eq("to_last_cycle_port", port_a, 8'h7E); check_eq("to_last_cycle_err", err_a, 0);
    tick; err_clr = 1'b1;
    smp;
    check_eq("to_next_port", port_a, 8'h7F);
    check_eq("to_err_set",   err_a,  1);
    check_eq("to_next_stb",  stb_a,  1);
    tick; err_clr = 1'b0;
    smp; check_eq("to_err_clr", err_a, 0);
    tick;
    repeat (12) tick;
    err_clr = 1'b1;
    smp; check_eq("to2_err_before", err_a, 0); check_eq("to2_stb_before", stb_a, 1);
    tick; err_clr = 1'b0;
    smp;
    check_eq("to2_set_wins",  err_a,  1);
    check_eq("to2_idle_stb",  stb_a,  0);
    check_eq("to2_port_kept", port_a, 8'h7F);
    tick;

    // Reset mid-handshake
    do_reset;
    for (int i = 0; i < 4; i++) begin
      out_we = 1'b1; out_data = 8'hC0 + 8'(i);
      tick;
    end
    out_we = 1'b0; rstn = 1'b0;
    smp; check_eq("mid_level", level_a, 3); check_eq("mid_stb", stb_a, 1);
    tick; rstn = 1'b1; o_ack = 1'b1;
    smp;
    check_eq("mid_rst_port",  port_a,  0);
    check_eq("mid_rst_stb",   stb_a,   0);
    check_eq("mid_rst_level", level_a, 0);
    tick;
    smp; check_eq("mid_no_stale_stb", stb_a, 0); check_eq("mid_no_stale_lvl", level_a, 0);
    tick;

    // Full boundary: push and pop in the same full cycle
    do_reset;
    for (int i = 0; i < 5; i++) begin
      out_we = 1'b1; out_data = 8'hB0 + 8'(i);
      tick;
    end
    out_data = 8'hB5; o_ack = 1'b1;
    smp; check_eq("fb_stall", stall_a, 1); check_eq("fb_level", level_a, 4);
    tick; o_ack = 1'b0;
    smp;
    check_eq("fb_accept_stall", stall_a, 0);
    check_eq("fb_accept_level", level_a, 3);
    check_eq("fb_accept_port",  port_a,  8'hB1);
    tick; out_we = 1'b0;
    smp; check_eq("fb_refull_level", level_a, 4); check_eq("fb_refull_stall", stall_a, 0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
